// File: rtl/dlfloat_pkg.sv
// Shared DLFloat16 definitions for the host side of the MAC byte link.
// Format: {sign, exp[5:0] (bias 31), mant[8:0]}. All-ones is NaN and all-zeros is zero.
// res_ent_t is one result FIFO entry. It holds the word plus the flags precomputed at push.
package dlfloat_pkg;
  localparam int DLF_W      = 16;
  localparam int DLF_EXP_W  = 6;
  localparam int DLF_MANT_W = 9;
  localparam int DLF_BIAS   = 31;
  localparam int LINK_W     = 8;

  typedef logic [DLF_W-1:0] dlf_t;

  localparam dlf_t DLF_NAN  = 16'hFFFF;
  localparam dlf_t DLF_ZERO = 16'h0000;

  typedef struct packed {
    logic nan;
    logic zero;
    dlf_t data;
  } res_ent_t;

  function automatic res_ent_t mk_ent(input dlf_t w);
    res_ent_t e;
    e.nan  = (w == DLF_NAN);
    e.zero = (w == DLF_ZERO);
    e.data = w;
    return e;
  endfunction
endpackage

// File: rtl/dlfloat_link_fifo.sv
// First-word-fall-through result FIFO. Each entry is 18 bits: {nan, zero, data}.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   push, wdata  write request and entry
//   pop          read request; it has no effect while the FIFO is empty
//   rdata        head entry, valid while empty is low
//   empty        no entries
//   count        occupancy, 0..DEPTH
// When the FIFO is full, a push is taken only if a pop happens in the same cycle.
// Pointers are AW bits wide. Because DEPTH is a power of two, they wrap modulo DEPTH for free.
module dlfloat_link_fifo
  import dlfloat_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  res_ent_t      wdata,
  input  logic          pop,
  output res_ent_t      rdata,
  output logic          empty,
  output logic [CW-1:0] count
);
  res_ent_t      mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/dlfloat_mac_link_host.sv
// Host-side end of the DLFloat16 MAC byte link.
// Operand pairs are sent over the 16-bit link bus: A in phase 0, then B in phase 1.
// Results come back from the MAC as a low byte and then a high byte. The host
// reassembles them at a fixed latency and queues them in a credit-protected FIFO.
// Ports:
//   clk, rst_n           clock, async active-low reset (shared with the MAC wrappers)
//   op_valid/op_ready    operand-pair handshake. op_ready is high only in phase 0 with credit.
//   op_a, op_b           DLFloat16 operands
//   link_data            16-bit bus to the MAC input
//   link_byte            MAC output byte
//   res_valid/res_ready  FWFT result handshake
//   res_data             head result; res_nan / res_zero are flags for that result
//   inflight             ops issued whose result is not yet pushed
module dlfloat_mac_link_host
  import dlfloat_pkg::*;
#(
  parameter  int RESULT_LAT = 6,
  parameter  int FIFO_DEPTH = 4,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  dlf_t              op_a,
  input  dlf_t              op_b,
  output dlf_t              link_data,
  input  logic [LINK_W-1:0] link_byte,
  output logic              res_valid,
  input  logic              res_ready,
  output dlf_t              res_data,
  output logic              res_nan,
  output logic              res_zero,
  output logic [CW-1:0]     inflight
);
  if ((RESULT_LAT < 2) || ((RESULT_LAT % 2) != 0)) begin : g_bad_lat
    $error("RESULT_LAT must be even and >= 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  logic                ph;          // link phase: 0 carries A, 1 carries B
  dlf_t                b_q;         // B for the phase-1 cycle; zero if no accept in phase 0
  logic [RESULT_LAT:1] vld_pipe;    // issue tracker: bit k is set k cycles after accept
  logic                hi_pend;     // the high result byte is on link_byte this cycle
  logic [LINK_W-1:0]   lo_q;
  logic                acc, push;
  logic [CW-1:0]       fifo_cnt;
  logic [CW:0]         credit;
  logic                empty;
  res_ent_t            head, ent_in;

  // Credit covers results still in flight as well as results already queued.
  // This means every accepted op has a FIFO slot reserved.
  assign credit   = {1'b0, inflight} + {1'b0, fifo_cnt};
  assign op_ready = rst_n & ~ph & (credit < (CW+1)'(FIFO_DEPTH));
  assign acc      = op_valid & op_ready;

  // No accept in phase 0 sends a zero operand pair to the MAC.
  assign link_data = ph ? b_q : (acc ? op_a : '0);

  // RESULT_LAT is even, so the low byte always arrives in phase 0 and the high byte in phase 1.
  assign push   = hi_pend;
  assign ent_in = mk_ent({link_byte, lo_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph       <= 1'b0;
      b_q      <= '0;
      vld_pipe <= '0;
      hi_pend  <= 1'b0;
      lo_q     <= '0;
      inflight <= '0;
    end else begin
      ph       <= ~ph;
      if (!ph) b_q <= acc ? op_b : '0;
      vld_pipe <= {vld_pipe[RESULT_LAT-1:1], acc};
      hi_pend  <= vld_pipe[RESULT_LAT];
      if (vld_pipe[RESULT_LAT]) lo_q <= link_byte;
      inflight <= inflight + CW'(acc) - CW'(push);
    end
  end

  dlfloat_link_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (ent_in),
    .pop   (res_ready),
    .rdata (head),
    .empty (empty),
    .count (fifo_cnt)
  );

  // The head is masked while the FIFO is empty, so stale entries never reach the outputs.
  assign res_valid = ~empty;
  assign res_data  = empty ? '0 : head.data;
  assign res_nan   = ~empty & head.nan;
  assign res_zero  = ~empty & head.zero;
endmodule
